// File: rtl/tohost_monitor_pkg.sv
// rtl/tohost_monitor_pkg.sv - shared constants, state codes and tohost hit decode
package tohost_monitor_pkg;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
    localparam logic [31:0] TOHOST_PASS         = 32'd1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_PASS    = 3'd2;
    localparam state_t ST_FAIL    = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    // Word-granular compare; only full-word stores count as a tohost write.
    function automatic logic tohost_hit(input logic        we,
                                        input logic [29:0] addr_word,
                                        input logic [3:0]  be,
                                        input logic [29:0] base_word);
        return we && (addr_word == base_word) && (be == 4'hF);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - snoops riscv-tests tohost stores and registers a verdict
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
    parameter int          MAX_CYCLES  = 5000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_be,
    input  logic             retire,
    output logic             halt,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      test_num,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t      state, state_n;
    logic [30:0] test_num_n;
    logic        hit;
    logic        running;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];
    assign hit     = tohost_hit(mem_we, mem_addr[31:2], mem_be, TOHOST_ADDR[31:2]);
    assign running = (state == ST_RUN);

    // A hit with a decodable verdict outranks the watchdog in the same cycle.
    always_comb begin
        state_n    = state;
        test_num_n = test_num;
        if (clear) begin
            state_n    = ST_IDLE;
            test_num_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (hit && (mem_wdata == TOHOST_PASS)) begin
                        state_n = ST_PASS;
                    end else if (hit && mem_wdata[0]) begin
                        state_n    = ST_FAIL;
                        test_num_n = mem_wdata[31:1];
                    end else if (cycle_count == WD_LAST) begin
                        state_n = ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            test_num <= '0;
        end else begin
            state    <= state_n;
            test_num <= test_num_n;
        end
    end

    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign timeout = (state == ST_TIMEOUT);
    assign done    = pass | fail | timeout;
    assign halt    = done;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (running),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (running && retire),
        .q   (retire_count)
    );

endmodule
